// File: rtl/systolic_feed_ctrl_pkg.sv
// Shared types and defaults for the systolic array operand feed controller.
package systolic_feed_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        FLUSH,
        DONE
    } feed_state_e;

    localparam int ROWS_DEF  = 4;
    localparam int DW_DEF    = 16;
    localparam int LEN_W_DEF = 8;

endpackage

// File: rtl/systolic_feed_ctrl_skew_line.sv
// Enable-gated delay line of {valid,data}; DEPTH=0 is a combinational pass-through.
module skew_line
    import systolic_feed_ctrl_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int DW    = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data
);

    if (DEPTH == 0) begin : g_pass
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst ^ en;
        assign out_valid = in_valid;
        assign out_data  = in_data;
    end else begin : g_shift
        logic [DEPTH-1:0]         valid_q;
        logic [DEPTH-1:0][DW-1:0] data_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= '0;
                data_q  <= '0;
            end else if (en) begin
                valid_q[0] <= in_valid;
                data_q[0]  <= in_data;
                for (int unsigned j = 1; j < DEPTH; j++) begin
                    valid_q[j] <= valid_q[j-1];
                    data_q[j]  <= data_q[j-1];
                end
            end
        end

        assign out_valid = valid_q[DEPTH-1];
        assign out_data  = data_q[DEPTH-1];
    end

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Loads one operand tile into the per-row FIFOs with diagonal skew, stalling on any full flag.
module systolic_feed_ctrl
    import systolic_feed_ctrl_pkg::*;
#(
    parameter int ROWS  = ROWS_DEF,
    parameter int DW    = DW_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_W-1:0]     len,
    input  logic                 src_valid,
    input  logic [ROWS*DW-1:0]   src_data,
    output logic                 src_ready,
    input  logic [ROWS-1:0]      fifo_ff,
    output logic                 fifo_start,
    output logic [ROWS-1:0]      fifo_we,
    output logic [ROWS*DW-1:0]   fifo_din,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CW-1:0] DRAIN_LAST = CW'((ROWS > 1) ? ROWS - 2 : 0);

    feed_state_e state, state_nx;

    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] beat_cnt;
    logic [CW-1:0]    drain_cnt;
    logic             adv;
    logic             accept;

    logic [ROWS-1:0]         stage_valid;
    logic [ROWS-1:0][DW-1:0] stage_data;

    assign adv    = ~|fifo_ff;
    assign accept = src_valid & src_ready;
    assign busy   = (state != IDLE);

    always_comb begin
        state_nx   = state;
        src_ready  = 1'b0;
        fifo_start = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = CLEAR;
            end
            CLEAR: begin
                fifo_start = 1'b1;
                state_nx   = (len_q == '0) ? DONE : FEED;
            end
            FEED: begin
                // The count is checked registered, so FEED lasts one cycle past the last beat.
                if (beat_cnt == len_q) begin
                    state_nx = (ROWS == 1) ? FLUSH : DRAIN;
                end else begin
                    src_ready = adv;
                end
            end
            DRAIN: begin
                if (adv && drain_cnt == DRAIN_LAST) state_nx = FLUSH;
            end
            FLUSH: begin
                state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            len_q     <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) len_q <= len;
            if (state == CLEAR) begin
                beat_cnt  <= '0;
                drain_cnt <= '0;
            end
            if (accept) beat_cnt <= beat_cnt + LEN_W'(1);
            if (state == DRAIN && adv) drain_cnt <= drain_cnt + CW'(1);
        end
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        skew_line #(
            .DEPTH (i),
            .DW    (DW)
        ) u_skew (
            .clk       (clk),
            .rst       (rst),
            .en        (adv),
            .in_valid  (accept),
            .in_data   (src_data[i*DW +: DW]),
            .out_valid (stage_valid[i]),
            .out_data  (stage_data[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_we  <= '0;
            fifo_din <= '0;
        end else begin
            for (int unsigned i = 0; i < ROWS; i++) begin
                fifo_we[i] <= adv & stage_valid[i];
                if (adv && stage_valid[i]) fifo_din[i*DW +: DW] <= stage_data[i];
            end
        end
    end

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Directed bench for systolic_feed_ctrl: timing, skew, stall, bubble, reset and start-while-busy.
module tb_systolic_feed_ctrl;

    localparam int ROWS  = 4;
    localparam int DW    = 16;
    localparam int LEN_W = 8;
    localparam int LOGN  = 512;

    logic               clk;
    logic               rst;
    logic               start;
    logic [LEN_W-1:0]   len;
    logic               src_valid;
    logic [ROWS*DW-1:0] src_data;
    logic               src_ready;
    logic [ROWS-1:0]    fifo_ff;
    logic               fifo_start;
    logic [ROWS-1:0]    fifo_we;
    logic [ROWS*DW-1:0] fifo_din;
    logic               busy;
    logic               done;

    systolic_feed_ctrl #(
        .ROWS  (ROWS),
        .DW    (DW),
        .LEN_W (LEN_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .src_valid  (src_valid),
        .src_data   (src_data),
        .src_ready  (src_ready),
        .fifo_ff    (fifo_ff),
        .fifo_start (fifo_start),
        .fifo_we    (fifo_we),
        .fifo_din   (fifo_din),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    int cyc = 0;
    int t0  = 0;
    logic rec_en = 1'b0;

    logic st_sched  [LOGN];
    logic gap       [LOGN];
    logic [ROWS-1:0] ff_sched [LOGN];
    logic rst_sched [LOGN];

    logic busy_log [LOGN];
    logic out_log  [LOGN];
    int   fs_q[$];
    int   rdy_q[$];
    int   acc_q[$];
    int   done_q[$];
    int   wr_cyc [ROWS][$];
    logic [DW-1:0] wr_dat [ROWS][$];

    always @(posedge clk) cyc <= cyc + 1;

    // Cycle index c counts rising edges since the cycle in which start was driven.
    always @(negedge clk) begin
        int c;
        #2;
        if (rec_en) begin
            c = cyc - t0;
            if (c >= 0 && c < LOGN) begin
                busy_log[c] = busy;
                out_log[c]  = |{src_ready, fifo_start, fifo_we, fifo_din, busy, done};
            end
            if (fifo_start) fs_q.push_back(c);
            if (src_ready) rdy_q.push_back(c);
            if (done) done_q.push_back(c);
            if (src_valid && src_ready) acc_q.push_back(c);
            for (int r = 0; r < ROWS; r++) begin
                if (fifo_we[r]) begin
                    wr_cyc[r].push_back(c);
                    wr_dat[r].push_back(fifo_din[r*DW +: DW]);
                end
            end
        end
    end

    function automatic logic [ROWS*DW-1:0] col(input int k);
        logic [ROWS*DW-1:0] d;
        for (int r = 0; r < ROWS; r++) d[r*DW +: DW] = {8'(r), 8'(k)};
        return d;
    endfunction

    task automatic clear_sched();
        for (int c = 0; c < LOGN; c++) begin
            st_sched[c]  = 1'b0;
            gap[c]       = 1'b0;
            ff_sched[c]  = '0;
            rst_sched[c] = 1'b0;
            busy_log[c]  = 1'b0;
            out_log[c]   = 1'b0;
        end
    endtask

    task automatic run(input logic [LEN_W-1:0] l, input int ncyc);
        fs_q.delete();
        rdy_q.delete();
        acc_q.delete();
        done_q.delete();
        for (int r = 0; r < ROWS; r++) begin
            wr_cyc[r].delete();
            wr_dat[r].delete();
        end
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (c == 0) begin
                t0     = cyc;
                rec_en = 1'b1;
            end
            start     = (c == 0) || st_sched[c];
            len       = l;
            src_valid = !gap[c];
            fifo_ff   = ff_sched[c];
            rst       = rst_sched[c];
            src_data  = col(acc_q.size());
        end
        @(negedge clk);
        start     = 1'b0;
        src_valid = 1'b0;
        fifo_ff   = '0;
        rst       = 1'b0;
        rec_en    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        len = '0;
        src_valid = 1'b0;
        src_data = '0;
        fifo_ff = '0;
        repeat (3) @(negedge clk);
        #2;
        total_cnt++;
        if (src_ready !== 1'b0) $display("FAIL reset_src_ready got %b want 0", src_ready); else pass_cnt++;
        total_cnt++;
        if (fifo_start !== 1'b0) $display("FAIL reset_fifo_start got %b want 0", fifo_start); else pass_cnt++;
        total_cnt++;
        if (fifo_we !== '0) $display("FAIL reset_fifo_we got %h want 0", fifo_we); else pass_cnt++;
        total_cnt++;
        if (fifo_din !== '0) $display("FAIL reset_fifo_din got %h want 0", fifo_din); else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
        total_cnt++;
        if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        clear_sched();
        run(8'd3, 14);
        total_cnt++;
        if (fs_q.size() != 1 || fs_q[0] != 1)
            $display("FAIL basic_fifo_start got n=%0d first=%0d want n=1 at 1", fs_q.size(), fs_q.size() ? fs_q[0] : -1);
        else pass_cnt++;
        total_cnt++;
        if (rdy_q.size() != 3 || rdy_q[0] != 2 || rdy_q[1] != 3 || rdy_q[2] != 4)
            $display("FAIL basic_src_ready got n=%0d want cycles 2,3,4", rdy_q.size());
        else pass_cnt++;
        for (int r = 0; r < ROWS; r++) begin
            total_cnt++;
            if (wr_cyc[r].size() != 3) $display("FAIL basic_row%0d_count got %0d want 3", r, wr_cyc[r].size());
            else pass_cnt++;
            for (int k = 0; k < 3 && k < wr_cyc[r].size(); k++) begin
                total_cnt++;
                if (wr_cyc[r][k] != 3 + r + k || wr_dat[r][k] !== {8'(r), 8'(k)})
                    $display("FAIL basic_row%0d_w%0d got cyc %0d data %h want cyc %0d data %h",
                             r, k, wr_cyc[r][k], wr_dat[r][k], 3 + r + k, {8'(r), 8'(k)});
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (done_q.size() != 1 || done_q[0] != 10)
            $display("FAIL basic_done got n=%0d first=%0d want one at 10", done_q.size(), done_q.size() ? done_q[0] : -1);
        else pass_cnt++;
        total_cnt++;
        if (busy_log[1] !== 1'b1 || busy_log[10] !== 1'b1 || busy_log[11] !== 1'b0)
            $display("FAIL basic_busy got %b%b%b want 110", busy_log[1], busy_log[10], busy_log[11]);
        else pass_cnt++;
    endtask

    task automatic test_zero_len();
        int nw;
        clear_sched();
        run(8'd0, 8);
        nw = 0;
        for (int r = 0; r < ROWS; r++) nw += wr_cyc[r].size();
        total_cnt++;
        if (fs_q.size() != 1 || fs_q[0] != 1) $display("FAIL zero_fifo_start got n=%0d want one at 1", fs_q.size());
        else pass_cnt++;
        total_cnt++;
        if (done_q.size() != 1 || done_q[0] != 2)
            $display("FAIL zero_done got n=%0d first=%0d want one at 2", done_q.size(), done_q.size() ? done_q[0] : -1);
        else pass_cnt++;
        total_cnt++;
        if (nw != 0 || rdy_q.size() != 0) $display("FAIL zero_writes got we=%0d ready=%0d want 0 0", nw, rdy_q.size());
        else pass_cnt++;
        total_cnt++;
        if (busy_log[3] !== 1'b0) $display("FAIL zero_busy_after got %b want 0", busy_log[3]);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        int exp_c [ROWS][3];
        exp_c = '{'{3, 4, 8}, '{4, 8, 9}, '{8, 9, 10}, '{9, 10, 11}};
        clear_sched();
        for (int c = 4; c <= 6; c++) ff_sched[c] = 4'b0100;
        run(8'd3, 18);
        for (int r = 0; r < ROWS; r++) begin
            total_cnt++;
            if (wr_cyc[r].size() != 3) $display("FAIL stall_row%0d_count got %0d want 3", r, wr_cyc[r].size());
            else pass_cnt++;
            for (int k = 0; k < 3 && k < wr_cyc[r].size(); k++) begin
                total_cnt++;
                if (wr_cyc[r][k] != exp_c[r][k] || wr_dat[r][k] !== {8'(r), 8'(k)})
                    $display("FAIL stall_row%0d_w%0d got cyc %0d data %h want cyc %0d data %h",
                             r, k, wr_cyc[r][k], wr_dat[r][k], exp_c[r][k], {8'(r), 8'(k)});
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (done_q.size() != 1 || done_q[0] != 13)
            $display("FAIL stall_done got n=%0d first=%0d want one at 13", done_q.size(), done_q.size() ? done_q[0] : -1);
        else pass_cnt++;
    endtask

    task automatic test_bubble();
        clear_sched();
        gap[3] = 1'b1;
        gap[4] = 1'b1;
        run(8'd3, 16);
        for (int r = 0; r < ROWS; r++) begin
            int exp_c [3];
            exp_c = '{3 + r, 6 + r, 7 + r};
            total_cnt++;
            if (wr_cyc[r].size() != 3) $display("FAIL bubble_row%0d_count got %0d want 3", r, wr_cyc[r].size());
            else pass_cnt++;
            for (int k = 0; k < 3 && k < wr_cyc[r].size(); k++) begin
                total_cnt++;
                if (wr_cyc[r][k] != exp_c[k] || wr_dat[r][k] !== {8'(r), 8'(k)})
                    $display("FAIL bubble_row%0d_w%0d got cyc %0d data %h want cyc %0d data %h",
                             r, k, wr_cyc[r][k], wr_dat[r][k], exp_c[k], {8'(r), 8'(k)});
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (done_q.size() != 1 || done_q[0] != 12)
            $display("FAIL bubble_done got n=%0d first=%0d want one at 12", done_q.size(), done_q.size() ? done_q[0] : -1);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_tile();
        clear_sched();
        rst_sched[5] = 1'b1;
        run(8'd3, 12);
        total_cnt++;
        if (wr_cyc[0].size() != 2 || wr_cyc[0][0] != 3 || wr_cyc[0][1] != 4)
            $display("FAIL midrst_row0 got n=%0d want cycles 3,4", wr_cyc[0].size());
        else pass_cnt++;
        total_cnt++;
        if (wr_cyc[1].size() != 1 || wr_cyc[2].size() != 0 || wr_cyc[3].size() != 0)
            $display("FAIL midrst_rows123 got %0d %0d %0d want 1 0 0",
                     wr_cyc[1].size(), wr_cyc[2].size(), wr_cyc[3].size());
        else pass_cnt++;
        total_cnt++;
        if (out_log[6] !== 1'b0 || busy_log[6] !== 1'b0)
            $display("FAIL midrst_outputs got any=%b busy=%b want 0 0", out_log[6], busy_log[6]);
        else pass_cnt++;
        total_cnt++;
        if (done_q.size() != 0) $display("FAIL midrst_done got %0d want 0", done_q.size());
        else pass_cnt++;
        clear_sched();
        run(8'd3, 14);
        total_cnt++;
        if (done_q.size() != 1 || done_q[0] != 10)
            $display("FAIL midrst_retile_done got n=%0d want one at 10", done_q.size());
        else pass_cnt++;
        for (int r = 0; r < ROWS; r++) begin
            total_cnt++;
            if (wr_cyc[r].size() != 3 || wr_cyc[r][0] != 3 + r || wr_dat[r][2] !== {8'(r), 8'(2)})
                $display("FAIL midrst_retile_row%0d got n=%0d want 3 writes from %0d", r, wr_cyc[r].size(), 3 + r);
            else pass_cnt++;
        end
    endtask

    task automatic test_start_while_busy();
        clear_sched();
        st_sched[3]  = 1'b1;
        st_sched[6]  = 1'b1;
        st_sched[9]  = 1'b1;
        st_sched[10] = 1'b1;
        run(8'd3, 16);
        total_cnt++;
        if (fs_q.size() != 1) $display("FAIL busystart_fifo_start got %0d want 1", fs_q.size());
        else pass_cnt++;
        total_cnt++;
        if (done_q.size() != 1 || done_q[0] != 10)
            $display("FAIL busystart_done got n=%0d want one at 10", done_q.size());
        else pass_cnt++;
        total_cnt++;
        if (busy_log[11] !== 1'b0) $display("FAIL busystart_idle got %b want 0", busy_log[11]);
        else pass_cnt++;
        for (int r = 0; r < ROWS; r++) begin
            total_cnt++;
            if (wr_cyc[r].size() != 3) $display("FAIL busystart_row%0d_count got %0d want 3", r, wr_cyc[r].size());
            else pass_cnt++;
        end
    endtask

    task automatic test_max_len();
        clear_sched();
        run(8'd255, 266);
        total_cnt++;
        if (wr_cyc[0].size() != 255 || wr_cyc[3].size() != 255)
            $display("FAIL maxlen_count got %0d %0d want 255 255", wr_cyc[0].size(), wr_cyc[3].size());
        else pass_cnt++;
        total_cnt++;
        if (wr_cyc[3].size() != 255 || wr_cyc[3][254] != 260 || wr_dat[3][254] !== 16'h03FE)
            $display("FAIL maxlen_row3_last got cyc %0d data %h want cyc 260 data 03fe",
                     wr_cyc[3].size() ? wr_cyc[3][wr_cyc[3].size()-1] : -1,
                     wr_dat[3].size() ? wr_dat[3][wr_dat[3].size()-1] : 16'h0);
        else pass_cnt++;
        total_cnt++;
        if (done_q.size() != 1 || done_q[0] != 262)
            $display("FAIL maxlen_done got n=%0d first=%0d want one at 262", done_q.size(), done_q.size() ? done_q[0] : -1);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_stall();
        test_bubble();
        test_reset_mid_tile();
        test_start_while_busy();
        test_max_len();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
